// File: rtl/input_memory_manager.sv
// Streams (z[i], m[j][i]) pairs with j rotating 0..7 per input row for the output memory manager.
// Optional zero-row skipping is enabled by defining INPUT_MEMORY_MANAGER_ZERO_SKIP_EN.
module input_memory_manager #(
  parameter int NUM_INPUTS = 16,
  parameter int IN_ADDR_W  = 4,
  parameter int W_ADDR_W   = 7
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 start,
  output logic [IN_ADDR_W-1:0] input_ram_address,
  output logic                 input_ram_enable,
  input  logic [15:0]          input_ram_data,
  output logic [W_ADDR_W-1:0]  weight_ram_address,
  output logic                 weight_ram_enable,
  input  logic [15:0]          weight_ram_data,
  output logic [15:0]          active_z,
  output logic [15:0]          active_m,
  output logic                 next_element,
  output logic                 last_element,
  output logic                 busy,
  output logic                 done,
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
  output logic [IN_ADDR_W:0]   skipped_rows,
`endif
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_Z_REQ  = 3'd1,
    S_Z_WAIT = 3'd2,
    S_W_REQ  = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [IN_ADDR_W-1:0] LAST_I = IN_ADDR_W'(NUM_INPUTS - 1);

  state_t               state_q;
  logic [IN_ADDR_W-1:0] i_q;
  logic [2:0]           j_q;
  logic [15:0]          z_q;
  logic                 zcap_q;
  logic                 rd_pend_q;
  logic [15:0]          skid_q;
  logic                 skid_vld_q;
  logic [15:0]          z_d;
  logic                 row_last;

  // z read data arrives in the first Z_WAIT cycle; later stalled cycles reuse the captured copy.
  assign z_d       = zcap_q ? z_q : input_ram_data;
  assign row_last  = (i_q == LAST_I);
  assign fsm_state = state_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q            <= S_IDLE;
      i_q                <= '0;
      j_q                <= '0;
      z_q                <= '0;
      zcap_q             <= 1'b0;
      rd_pend_q          <= 1'b0;
      skid_q             <= '0;
      skid_vld_q         <= 1'b0;
      input_ram_address  <= '0;
      input_ram_enable   <= 1'b0;
      weight_ram_address <= '0;
      weight_ram_enable  <= 1'b0;
      active_z           <= '0;
      active_m           <= '0;
      next_element       <= 1'b0;
      last_element       <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
      skipped_rows       <= '0;
`endif
    end else begin
      zcap_q <= (state_q == S_Z_WAIT);
      if (state_q == S_Z_WAIT) z_q <= z_d;
      if (!en) begin
        next_element <= 1'b0;
        last_element <= 1'b0;
        // A weight read issued just before the stall lands here; hold it until en returns.
        if (rd_pend_q && !skid_vld_q) begin
          skid_q     <= weight_ram_data;
          skid_vld_q <= 1'b1;
        end
      end else begin
        rd_pend_q    <= weight_ram_enable;
        skid_vld_q   <= 1'b0;
        next_element <= rd_pend_q;
        last_element <= 1'b0;
        if (rd_pend_q) begin
          active_m <= skid_vld_q ? skid_q : weight_ram_data;
          active_z <= z_q;
        end
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q           <= S_Z_REQ;
              busy              <= 1'b1;
              done              <= 1'b0;
              i_q               <= '0;
              input_ram_enable  <= 1'b1;
              input_ram_address <= '0;
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
              skipped_rows      <= '0;
`endif
            end
          end
          S_Z_REQ: begin
            input_ram_enable <= 1'b0;
            state_q          <= S_Z_WAIT;
          end
          S_Z_WAIT: begin
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
            if (z_d == 16'd0) begin
              skipped_rows <= skipped_rows + 1'b1;
              if (row_last) begin
                state_q <= S_DRAIN;
              end else begin
                i_q               <= i_q + 1'b1;
                input_ram_enable  <= 1'b1;
                input_ram_address <= i_q + 1'b1;
                state_q           <= S_Z_REQ;
              end
            end else
`endif
            begin
              j_q                <= '0;
              weight_ram_enable  <= 1'b1;
              weight_ram_address <= {i_q, 3'd0};
              state_q            <= S_W_REQ;
            end
          end
          S_W_REQ: begin
            if (j_q == 3'd7) begin
              weight_ram_enable <= 1'b0;
              j_q               <= '0;
              if (row_last) begin
                state_q <= S_DRAIN;
              end else begin
                i_q               <= i_q + 1'b1;
                input_ram_enable  <= 1'b1;
                input_ram_address <= i_q + 1'b1;
                state_q           <= S_Z_REQ;
              end
            end else begin
              j_q                <= j_q + 3'd1;
              weight_ram_address <= {i_q, j_q + 3'd1};
            end
          end
          S_DRAIN: begin
            // Wait for the final in-flight weight to be presented before flagging the end.
            if (!rd_pend_q) begin
              last_element <= 1'b1;
              busy         <= 1'b0;
              done         <= 1'b1;
              state_q      <= S_DONE;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_memory_manager.sv
// Directed bench for input_memory_manager with two input rows: table-driven passes plus
// hand-written clear-abort sequence; pairs are scored against a bench-built expected queue.
module tb_input_memory_manager;
  localparam int NI  = 2;
  localparam int IAW = 1;
  localparam int WAW = 4;

  logic           clock = 1'b0;
  logic           clear;
  logic           en;
  logic           start;
  logic [IAW-1:0] input_ram_address;
  logic           input_ram_enable;
  logic [15:0]    input_ram_data;
  logic [WAW-1:0] weight_ram_address;
  logic           weight_ram_enable;
  logic [15:0]    weight_ram_data;
  logic [15:0]    active_z;
  logic [15:0]    active_m;
  logic           next_element;
  logic           last_element;
  logic           busy;
  logic           done;
  logic [2:0]     fsm_state;
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
  logic [IAW:0]   skipped_rows;
`endif

  input_memory_manager #(.NUM_INPUTS(NI), .IN_ADDR_W(IAW), .W_ADDR_W(WAW)) dut (
    .clock(clock), .clear(clear), .en(en), .start(start),
    .input_ram_address(input_ram_address), .input_ram_enable(input_ram_enable),
    .input_ram_data(input_ram_data),
    .weight_ram_address(weight_ram_address), .weight_ram_enable(weight_ram_enable),
    .weight_ram_data(weight_ram_data),
    .active_z(active_z), .active_m(active_m),
    .next_element(next_element), .last_element(last_element),
    .busy(busy), .done(done),
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
    .skipped_rows(skipped_rows),
`endif
    .fsm_state(fsm_state)
  );

  always #5 clock = ~clock;

  // One-cycle-latency RAM models.
  logic [15:0] zmem [NI];
  logic [15:0] wmem [8*NI];
  always @(posedge clock) begin
    if (input_ram_enable)  input_ram_data  <= zmem[input_ram_address];
    if (weight_ram_enable) weight_ram_data <= wmem[weight_ram_address];
  end

  typedef struct {
    logic [15:0] z0;
    logic [15:0] z1;
    int          stall_after;
    int          stall_len;
    int          restart_at;
    int          exp_extra;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          base_cyc = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_addr"}, 32'(input_ram_address), 32'd0);
    check({tag, "_in_en"},   32'(input_ram_enable), 32'd0);
    check({tag, "_w_addr"},  32'(weight_ram_address), 32'd0);
    check({tag, "_w_en"},    32'(weight_ram_enable), 32'd0);
    check({tag, "_z"},       32'(active_z), 32'd0);
    check({tag, "_m"},       32'(active_m), 32'd0);
    check({tag, "_next"},    32'(next_element), 32'd0);
    check({tag, "_last"},    32'(last_element), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_done"},    32'(done), 32'd0);
    check({tag, "_state"},   32'(fsm_state), 32'd0);
  endtask

  task automatic run_pass(input vec_t v, input int idx);
    int          cyc, strobes, lasts, last_cyc, last_strobe, n_exp, stall_left, zeros;
    bit          stalled, restarted;
    logic [15:0] zr;
    logic [31:0] e;
    logic [31:0] acc[8];
    cyc = 0; strobes = 0; lasts = 0; last_cyc = 0; last_strobe = 0;
    stall_left = 0; zeros = 0; stalled = 0; restarted = 0;
    for (int k = 0; k < 8; k++) acc[k] = 0;
    zmem[0] = v.z0;
    zmem[1] = v.z1;
    exp_q.delete();
    for (int r = 0; r < NI; r++) begin
      zr = (r == 0) ? v.z0 : v.z1;
      if (zr == 16'd0) zeros++;
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
      if (zr != 16'd0)
`endif
        for (int j = 0; j < 8; j++) exp_q.push_back({zr, 16'(16 * r + j)});
    end
    n_exp = exp_q.size();
    @(negedge clock); en = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (cyc < 400 && !(lasts > 0 && cyc >= last_cyc + 3)) begin
      if (!en) check("stall_strobes", 32'({next_element, last_element}), 32'd0);
      if (next_element) begin
        acc[strobes % 8] += 32'(active_z) * 32'(active_m);
        strobes++;
        last_strobe = cyc;
        if (exp_q.size() == 0) check("extra_strobe", 32'(strobes), 32'(n_exp));
        else begin
          e = exp_q.pop_front();
          check("pair", {active_z, active_m}, e);
        end
      end
      if (last_element) begin lasts++; last_cyc = cyc; end
      if (!stalled && v.stall_len > 0 && strobes == v.stall_after) begin
        stalled = 1; en = 1'b0; stall_left = v.stall_len;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) en = 1'b1;
      end
      if (start) start = 1'b0;
      else if (!restarted && strobes == v.restart_at) begin start = 1'b1; restarted = 1; end
      @(negedge clock); cyc++;
    end
    start = 1'b0;
    check("last_count", 32'(lasts), 32'd1);
    check("strobe_count", 32'(strobes), 32'(n_exp));
    check("leftover", 32'(exp_q.size()), 32'd0);
    if (n_exp > 0) check("last_gap", 32'(last_cyc), 32'(last_strobe + 1));
    check("done_held", 32'(done), 32'd1);
    check("busy_low", 32'(busy), 32'd0);
    check("idle_state", 32'(fsm_state), 32'd0);
    if (v.z0 == 16'd3 && v.z1 == 16'd5) begin
      check("acc_w0", acc[0], 32'd80);
      check("acc_w7", acc[7], 32'd136);
    end
`ifdef INPUT_MEMORY_MANAGER_ZERO_SKIP_EN
    check("skipped_rows", 32'(skipped_rows), 32'(zeros));
`endif
    if (idx == 0) base_cyc = last_cyc;
    else if (v.exp_extra >= 0) check("pass_len", 32'(last_cyc - base_cyc), 32'(v.exp_extra));
  endtask

  task automatic clear_sequence();
    int cyc, strobes, lasts;
    cyc = 0; strobes = 0; lasts = 0;
    zmem[0] = 16'd3;
    zmem[1] = 16'd5;
    @(negedge clock); en = 1'b1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (strobes < 10 && cyc < 100) begin
      if (next_element) strobes++;
      @(negedge clock); cyc++;
    end
    check("clr_reach_row2", 32'(strobes), 32'd10);
    #2 clear = 1'b1;
    #1 check_all_zero("clr");
    @(negedge clock); clear = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (last_element) lasts++;
      @(negedge clock);
    end
    check("clr_no_last", 32'(lasts), 32'd0);
    check("clr_idle", 32'(fsm_state), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 8 * NI; a++) wmem[a] = 16'(16 * (a / 8) + (a % 8));
    zmem[0] = 16'd0;
    zmem[1] = 16'd0;
    clear = 1'b1; en = 1'b0; start = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    clear = 1'b0;
    @(negedge clock);
    check("idle_no_start", 32'(busy), 32'd0);

    vecs[0] = '{z0: 16'd3,      z1: 16'd5, stall_after: -1, stall_len: 0, restart_at: -1, exp_extra: 0};
    vecs[1] = '{z0: 16'd3,      z1: 16'd5, stall_after: 4,  stall_len: 3, restart_at: -1, exp_extra: 3};
    vecs[2] = '{z0: 16'd3,      z1: 16'd5, stall_after: -1, stall_len: 0, restart_at: 6,  exp_extra: 0};
    vecs[3] = '{z0: 16'hFFFF,   z1: 16'd1, stall_after: 11, stall_len: 2, restart_at: 0,  exp_extra: 2};
    vecs[4] = '{z0: 16'd0,      z1: 16'd7, stall_after: -1, stall_len: 0, restart_at: -1, exp_extra: -1};
    vecs[5] = '{z0: 16'd0,      z1: 16'd0, stall_after: -1, stall_len: 0, restart_at: -1, exp_extra: -1};
    for (int k = 0; k < 6; k++) run_pass(vecs[k], k);

    clear_sequence();
    run_pass(vecs[0], 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
